audio_feed: RTL
===============

# audio_feed

Audio sample feeder that sits directly upstream of the FM transmitter. Accepts 10-bit unsigned PCM samples over a valid/ready handshake and buffers them in a small FIFO. Releases exactly one sample per audio sample period, using an internal clock divider, onto a held output bus that drives the transmitter's audio input. Underruns are flagged and replaced with midscale silence.

## Interface
- `DW`, 10, sample width in bits (unsigned, offset-binary)
- `DEPTH`, 16, FIFO depth in entries; must be a power of 2
- `TICK_DIV`, 1134, clk cycles per output sample (50 MHz / 1134 ≈ 44.09 kHz); must be ≥ 2
- `clk`  in  1  system clock; the block's only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `s_data`  in  DW  input sample
- `s_valid`  in  1  `s_data` is valid
- `s_ready`  out  1  FIFO can accept (`= !full`, from registered state)
- `data_out`  out  DW  current audio sample to the transmitter; held between updates
- `sample_stb`  out  1  one-cycle pulse, high the cycle `data_out` takes a new value
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- `underrun`  out  1  one-cycle pulse when a tick finds the FIFO empty

## Operation
- **Push:** on a rising edge with `s_valid && s_ready`, write `s_data` at the write pointer. The write pointer wraps modulo DEPTH.
- **Divider:**
  - `div` counts 0..TICK_DIV-1 and wraps to 0.
  - Internal `tick` is asserted when `div == TICK_DIV-1`.
  - The divider free-runs and is never gated by FIFO state.
- **Pop on tick, FIFO not empty (registered level > 0):**
  - `data_out` takes the head entry.
  - The read pointer advances and wraps modulo DEPTH.
  - `sample_stb` pulses.
- **Pop on tick, FIFO empty:**
  - `data_out` takes midscale, `2**(DW-1)` (512 for DW=10).
  - `sample_stb` and `underrun` both pulse.
  - The read pointer does not move.
- **Level update:** `level` = previous level + push − pop, where pop is 1 only on a non-empty tick.
- **Simultaneous push and pop:** level is unchanged and both pointers advance.
- **Push while full:** `s_ready` is computed from the registered `full`, so a push is refused at level DEPTH even if a pop occurs in the same cycle. There is no bypass.
- **Push while empty on a tick:** the tick underruns (it sees the old, empty level). The pushed sample is stored and is emitted on the next tick.
- **Data integrity:** no sample is ever dropped or duplicated. Input order is preserved.
- **Reset, asserted at any time:**
  - Pointers, `level` and `div` clear to 0. FIFO contents are discarded; the storage array itself needs no reset.
  - `data_out` = midscale; `sample_stb` = 0; `underrun` = 0.
  - `s_ready` = 1, but no writes are accepted while `rst_n` is low.

## Timing
- All outputs are registered except `s_ready`. `s_ready` is combinational from registered `full` and involves no `s_valid` path.
- `data_out`, `sample_stb` and `underrun` update on the edge following the cycle in which `tick` is high (1-cycle latency).
- First tick: `div` reaches TICK_DIV-1 on the TICK_DIV-th edge after reset release. The first `sample_stb` is high during the following cycle.
- Consecutive `sample_stb` pulses are exactly TICK_DIV cycles apart.
- A sample accepted on edge t can appear on `data_out` no earlier than the first tick strictly after t.
- `level` and `s_ready` reflect a push or pop at the edge on which it occurs.

## Configuration
- Macro: `AUDIO_FEED_UNDERRUN_CNT_EN`.
- **Defined:**
  - Adds output `underrun_cnt  out  16`.
  - Reset value 0; increments on each `underrun` pulse.
  - Saturates at 65535 and does not wrap.
  - Cleared only by reset.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset values:** hold `rst_n` low with `s_valid`=1 → `data_out`=512, `sample_stb`=0, `underrun`=0, `level`=0, `s_ready`=1. After release, `level` is still 0.
- **Normal drain then underrun:** push 100, 200, 300 back-to-back after reset.
  - Expect `sample_stb` at cycles TICK_DIV+1, 2·TICK_DIV+1 and 3·TICK_DIV+1, with `data_out` = 100, 200, 300.
  - The 4th tick gives `data_out`=512 with `underrun`=1 for one cycle.
- **Full and backpressure:** push 16 samples 0..15 → `level`=16, `s_ready`=0.
  - Hold `s_valid` with value 99: it is not accepted.
  - After the next tick (`data_out`=0): `level`=15, `s_ready`=1, and 99 is accepted on the following edge.
- **Simultaneous push/pop:** at `level`=5, assert a push in the tick cycle → `level` remains 5 and `data_out` = the oldest sample.
- **Reset mid-operation:** at `level`=8, pulse `rst_n` low for 1 cycle → `level`=0, `data_out`=512. The first post-reset tick underruns.
- **With `AUDIO_FEED_UNDERRUN_CNT_EN`:** run 3 empty ticks → `underrun_cnt`=3. Force 65536 underruns → `underrun_cnt` stays at 65535.

Source files
------------

// File: rtl/audio_feed.sv
// audio_feed: PCM sample feeder for the FM transmitter audio input.
// Samples enter a small FIFO over a valid/ready handshake and are released
// one per audio sample period (TICK_DIV clk cycles) onto a held output bus.
// An empty FIFO at a tick produces midscale silence and an underrun pulse.
// Optional feature macro: AUDIO_FEED_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun counter output.
module audio_feed #(
    parameter int DW       = 10,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 1134
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DW-1:0]            data_out,
    output logic                     sample_stb,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
`ifdef AUDIO_FEED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] div_q, div_d;
    logic [DW-1:0] data_q, data_d;
    logic          stb_q, stb_d;
    logic          und_q, und_d;

    logic full;
    logic empty;
    logic tick;
    logic push;
    logic pop;

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready.
    // s_ready depends only on registered occupancy (never on s_valid), so a
    // full FIFO refuses a push even if a pop happens on that same edge.
    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign tick    = (div_q == DIV_LAST);
    assign s_ready = !full;
    assign push    = s_valid && s_ready && rst_n;
    assign pop     = tick && !empty;

    assign data_out   = data_q;
    assign sample_stb = stb_q;
    assign level      = level_q;
    assign underrun   = und_q;

    // Sample storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Next-state: free-running divider, pointer/level update, output on tick.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        stb_d    = 1'b0;
        und_d    = 1'b0;
        div_d    = tick ? '0 : div_q + CW'(1);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (tick) begin
            stb_d = 1'b1;
            if (empty) begin
                data_d = MIDSCALE;
                und_d  = 1'b1;
            end else begin
                data_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            div_q    <= '0;
            data_q   <= MIDSCALE;
            stb_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            div_q    <= div_d;
            data_q   <= data_d;
            stb_q    <= stb_d;
            und_q    <= und_d;
        end
    end

`ifdef AUDIO_FEED_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    assign underrun_cnt = ucnt_q;

    // Saturating underrun count, advancing on the edge the underrun pulse starts.
    always_comb begin
        ucnt_d = ucnt_q;
        if (tick && empty && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    // Underrun counter register; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end
`endif

endmodule
